// File: rtl/updown_counter_param.sv
// Parametrised WIDTH-bit up/down counter over MIN_VAL..MAX_VAL with wrap/saturate, load, tc, evt and sticky ovf.
// Latency: count/evt/ovf registered, 1 cycle after the sampling edge; tc is combinational from count and m.
// Backpressure: none; en throttles stepping. Optional enable prescaler under macro PRESCALE_EN.
module updown_counter_param #(
    parameter int unsigned         WIDTH    = 8,
    parameter logic [WIDTH-1:0]    MIN_VAL  = '0,
    parameter logic [WIDTH-1:0]    MAX_VAL  = {WIDTH{1'b1}},
    parameter int unsigned         PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m,
    input  logic             en,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             evt,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             evt_q, evt_d;
    logic             ovf_q, ovf_d;
    logic             step_go;

    // Borrow bits of the range subtractions give the clamp decisions without
    // constant-folding comparisons when a bound sits at the edge of the width.
    logic [WIDTH:0]   below_diff, above_diff;
    logic             load_below, load_above;
    logic [WIDTH-1:0] load_clamped;

    assign below_diff   = {1'b0, load_val} - {1'b0, MIN_VAL};
    assign above_diff   = {1'b0, MAX_VAL} - {1'b0, load_val};
    assign load_below   = below_diff[WIDTH];
    assign load_above   = above_diff[WIDTH];
    assign load_clamped = load_below ? MIN_VAL : (load_above ? MAX_VAL : load_val);

`ifdef PRESCALE_EN
    localparam int unsigned      PW     = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PS_TOP = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PS_ONE = PW'(1);

    logic [PW-1:0] pre_q, pre_d;

    assign step_go = en && (pre_q == PS_TOP);

    always_comb begin
        pre_d = pre_q;
        if (reset || load) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = (pre_q == PS_TOP) ? '0 : pre_q + PS_ONE;
        end
    end

    always_ff @(posedge clk) begin
        pre_q <= pre_d;
    end
`else
    assign step_go = en;
`endif

    always_comb begin
        count_d = count_q;
        evt_d   = 1'b0;
        ovf_d   = ovf_q && !ovf_clr;
        if (reset) begin
            count_d = m ? MIN_VAL : MAX_VAL;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (step_go) begin
            if (m) begin
                if (count_q == MAX_VAL) begin
                    count_d = sat ? MAX_VAL : MIN_VAL;
                    evt_d   = 1'b1;
                end else begin
                    count_d = count_q + ONE_W;
                end
            end else begin
                if (count_q == MIN_VAL) begin
                    count_d = sat ? MIN_VAL : MAX_VAL;
                    evt_d   = 1'b1;
                end else begin
                    count_d = count_q - ONE_W;
                end
            end
            // A boundary step sets ovf even if a clear arrives the same cycle.
            if (evt_d) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
        evt_q   <= evt_d;
        ovf_q   <= ovf_d;
    end

    assign count = count_q;
    assign evt   = evt_q;
    assign ovf   = ovf_q;
    assign tc    = (m && (count_q == MAX_VAL)) || (!m && (count_q == MIN_VAL));

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param (WIDTH=4, range 0..9): directed plan then random cycles vs a reference model.
module tb_updown_counter_param;

    localparam int W     = 4;
    localparam int MINV  = 0;
    localparam int MAXV  = 9;
    localparam int PS    = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         m = 1'b1;
    logic         en = 1'b0;
    logic         sat = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         ovf_clr = 1'b0;
    logic [W-1:0] count;
    logic         tc, evt, ovf;

    int errors = 0;
    int checks = 0;

    // reference state
    int mc = 0;
    int me = 0;
    int mo = 0;
    int mp = 0;

    updown_counter_param #(
        .WIDTH(W), .MIN_VAL(4'(MINV)), .MAX_VAL(4'(MAXV)), .PRESCALE(PS)
    ) dut (
        .clk(clk), .reset(reset), .m(m), .en(en), .sat(sat), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(count), .tc(tc),
        .evt(evt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model of one edge: take the step in plain integers, then fix up range.
    task automatic model_edge(input int r, input int ld, input int lv, input int e,
                              input int mm, input int s, input int clr);
        int nxt;
        int go;
        if (r != 0) begin
            mc = (mm != 0) ? MINV : MAXV;
            me = 0; mo = 0; mp = 0;
        end else if (ld != 0) begin
            mc = (lv < MINV) ? MINV : ((lv > MAXV) ? MAXV : lv);
            me = 0; mp = 0;
            mo = (clr != 0) ? 0 : mo;
        end else begin
            go = e;
`ifdef PRESCALE_EN
            if (e != 0) begin
                go = (mp == PS - 1) ? 1 : 0;
                mp = (mp + 1) % PS;
            end
`endif
            me = 0;
            if (go != 0) begin
                nxt = mc + ((mm != 0) ? 1 : -1);
                if (nxt > MAXV || nxt < MINV) begin
                    me  = 1;
                    nxt = (s != 0) ? mc : ((mm != 0) ? MINV : MAXV);
                end
                mc = nxt;
            end
            mo = (me != 0) ? 1 : ((clr != 0) ? 0 : mo);
        end
    endtask

    task automatic cyc(input string tag, input int r, input int ld, input int lv,
                       input int e, input int mm, input int s, input int clr);
        reset = (r != 0); load = (ld != 0); load_val = W'(lv); en = (e != 0);
        m = (mm != 0); sat = (s != 0); ovf_clr = (clr != 0);
        @(posedge clk);
        model_edge(r, ld, lv, e, mm, s, clr);
        #1;
        check({tag, ".count"}, int'(count), mc);
        check({tag, ".evt"}, int'(evt), me);
        check({tag, ".ovf"}, int'(ovf), mo);
        check({tag, ".tc"}, int'(tc),
              ((mm != 0 && mc == MAXV) || (mm == 0 && mc == MINV)) ? 1 : 0);
    endtask

    initial begin
        int mseq[5];
        int evt_hits;
        mseq = '{1, 1, 0, 0, 0};

        // reset values, both directions
        cyc("rst_up", 1, 0, 0, 0, 1, 0, 0);
        check("rst_up.const", int'(count), 0);
        cyc("rst_dn", 1, 0, 0, 0, 0, 0, 0);
        check("rst_dn.const", int'(count), 9);
        cyc("rst_up2", 1, 0, 0, 0, 1, 0, 0);

        // decade wrap up
        evt_hits = 0;
        for (int i = 0; i < 12; i++) begin
            cyc("wrap_up", 0, 0, 0, 1, 1, 0, 0);
            evt_hits += int'(evt);
        end
`ifndef PRESCALE_EN
        check("wrap_up.final", int'(count), 2);
        check("wrap_up.evt_count", evt_hits, 1);
        check("wrap_up.ovf", int'(ovf), 1);
`endif

        // saturate down from 2
        cyc("ld2", 0, 1, 2, 0, 0, 1, 0);
        evt_hits = 0;
        for (int i = 0; i < 5; i++) begin
            cyc("sat_dn", 0, 0, 0, 1, 0, 1, 0);
            evt_hits += int'(evt);
        end
`ifndef PRESCALE_EN
        check("sat_dn.evt_count", evt_hits, 3);
        check("sat_dn.final", int'(count), 0);
`endif
        cyc("clr_vs_set", 0, 0, 0, 1, 0, 1, 1);
        cyc("clr_idle", 0, 0, 0, 0, 0, 1, 1);
        check("clr_idle.const", int'(ovf), 0);

        // load priority and clamping, then reset beats load
        cyc("ld_clamp", 0, 1, 13, 1, 1, 0, 0);
        check("ld_clamp.const", int'(count), 9);
        cyc("rst_beats_ld", 1, 1, 4, 1, 1, 0, 0);
        check("rst_beats_ld.const", int'(count), 0);

        // direction change mid-run
        cyc("ld5", 0, 1, 5, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc("dir_chg", 0, 0, 0, 1, mseq[i], 0, 0);
        end
`ifndef PRESCALE_EN
        check("dir_chg.final", int'(count), 4);
`endif

`ifdef PRESCALE_EN
        cyc("ps_rst", 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc("ps_run", 0, 0, 0, 1, 1, 0, 0);
        check("ps_run.const", int'(count), 2);
        for (int i = 0; i < 2; i++) cyc("ps_run2", 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) cyc("ps_hold", 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) cyc("ps_run3", 0, 0, 0, 1, 1, 0, 0);
        check("ps_delay.const", int'(count), 3);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand",
                ($urandom_range(0, 39) == 0) ? 1 : 0,
                ($urandom_range(0, 9) == 0) ? 1 : 0,
                int'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0) ? 1 : 0,
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised successor to the team's fixed 4-bit up/down counter. It provides a WIDTH-bit up/down counter with a programmable MIN_VAL..MAX_VAL range, selectable wrap or saturate at the bounds, and synchronous parallel load. It also has a count enable, a terminal-count flag, a registered boundary event pulse and a sticky overflow flag. It is used as the shared counter primitive for timers, decade counters and address sequencers in later sequential blocks.

Parameters:
WIDTH, 8, counter width in bits (>=2)
MIN_VAL, 0, lower bound of the count range
MAX_VAL, 2**WIDTH-1, upper bound of the count range; MIN_VAL < MAX_VAL <= 2**WIDTH-1
PRESCALE, 4, enable divide ratio (>=2); used only when PRESCALE_EN is defined

Ports:
clk  input  1  clock, all state updates on the rising edge
reset  input  1  synchronous, active-high reset
m  input  1  direction: 1 = count up, 0 = count down
en  input  1  count enable; one step per enabled cycle
sat  input  1  boundary mode: 1 = saturate, 0 = wrap
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value captured on load
ovf_clr  input  1  clears the sticky ovf flag
count  output  WIDTH  registered counter value
tc  output  1  terminal count: (m & count==MAX_VAL) | (~m & count==MIN_VAL); combinational from count and m
evt  output  1  registered 1-cycle pulse: a step was attempted at the bound
ovf  output  1  sticky flag, set on any evt

Behaviour:
- Per-edge priority: reset > load > en step > hold.
- Reset, sampled on the rising edge:
  - count <= MIN_VAL if m=1, MAX_VAL if m=0 (direction-dependent, as in the 4-bit counter).
  - evt <= 0, ovf <= 0, prescaler <= 0.
- Load: count <= load_val, clamped into range (<MIN_VAL gives MIN_VAL, >MAX_VAL gives MAX_VAL).
  - evt <= 0 and the prescaler clears.
  - en is ignored that cycle.
- Step (en=1, no load/reset):
  - Up, count<MAX_VAL: count+1. Down, count>MIN_VAL: count-1.
  - Up at MAX_VAL: wrap to MIN_VAL (sat=0) or hold MAX_VAL (sat=1). evt <= 1.
  - Down at MIN_VAL: wrap to MAX_VAL (sat=0) or hold MIN_VAL (sat=1). evt <= 1.
- Hold (en=0): count unchanged; evt <= 0.
- evt is high for exactly one cycle per boundary step. Continuous en at a saturated bound gives evt=1 every cycle.
- ovf:
  - set when the next evt is 1;
  - cleared by ovf_clr;
  - if set and clear occur in the same cycle, set wins;
  - cleared by reset.
- Arithmetic is WIDTH bits, compare unsigned. No intermediate value leaves [MIN_VAL, MAX_VAL].
- m may change on any cycle. The new direction applies to that cycle's step and tc reflects it immediately.
- Latency: count, evt and ovf update 1 cycle after the sampling edge. tc is 0-cycle from count and m.

Optional Feature:
PRESCALE_EN
- Defined:
  - An internal counter of $clog2(PRESCALE) bits advances on en=1 cycles.
  - The counter steps only on the en cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - evt and ovf are qualified by that same step.
  - en=0 freezes the prescaler.
  - load and reset clear the prescaler.
- Not defined: no prescaler logic; every en=1 cycle is a step.

Test Plan:
- Reset values (WIDTH=4, MIN_VAL=0, MAX_VAL=9): reset=1 with m=1 -> count=0, evt=0, ovf=0. Reset=1 with m=0 -> count=9.
- Decade wrap up: m=1, sat=0, en=1 for 12 cycles from 0 -> count 1..9, 0, 1, 2. evt=1 only in the cycle after the 9->0 step. ovf=1 afterwards. tc=1 while count=9.
- Saturate down: m=0, sat=1, en=1 from count=2 for 5 cycles -> 1, 0, 0, 0, 0. evt=1 on each of the last 3 steps. Then ovf_clr=1 with en=1 -> ovf stays 1 (set wins). ovf_clr=1 with en=0 -> ovf=0.
- Load priority and clamping: load=1, en=1, load_val=13 -> count=9, not 10 or 0. Next cycle load_val=4 with reset=1 -> count=0 (reset wins).
- Direction change mid-run: count=5, en=1; m=1,1,0,0,0 -> 6, 7, 6, 5, 4. tc=0 throughout.
- PRESCALE_EN, PRESCALE=4: en=1 for 8 cycles from 0 -> count steps to 1 on the 4th cycle and 2 on the 8th. en low for 2 cycles mid-sequence delays the step by 2 cycles.
